// File: rtl/akuma_pkg.sv
// Shared types and screen geometry for the Akuma motion controller.
package akuma_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 140;
  localparam int SPRITE_H = 240;

  typedef enum logic [1:0] {
    POSE_STAND = 2'd0,
    POSE_WALK  = 2'd1,
    POSE_JUMP  = 2'd2,
    POSE_LAND  = 2'd3
  } pose_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_STAND = 2'd0;
  localparam state_t ST_WALK  = 2'd1;
  localparam state_t ST_AIR   = 2'd2;
  localparam state_t ST_LAND  = 2'd3;

  function automatic pose_t state_to_pose(state_t s);
    case (s)
      ST_WALK: return POSE_WALK;
      ST_AIR:  return POSE_JUMP;
      ST_LAND: return POSE_LAND;
      default: return POSE_STAND;
    endcase
  endfunction

endpackage

// File: rtl/akuma_motion_controller_frame_tick_gen.sv
// Detects the falling edge of vertical sync: tick is the combinational
// update enable, frame_tick its registered one-cycle copy.
module frame_tick_gen (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic vs,
  output logic tick,
  output logic frame_tick
);

  logic vs_q;

  assign tick = vs_q & ~vs;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vs;
      frame_tick <= tick;
    end
  end

endmodule

// File: rtl/akuma_motion_controller.sv
// Once-per-frame walk/jump/land state machine driving Akuma's sprite
// position, mirror flag and pose select.
module akuma_motion_controller
  import akuma_pkg::*;
#(
  parameter int X_START     = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - SPRITE_W,
  parameter int GROUND_Y    = SCREEN_H - SPRITE_H,
  parameter int WALK_STEP   = 3,
  parameter int JUMP_V0     = 14,
  parameter int GRAVITY     = 1,
  parameter int LAND_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic       facing_left,
  output logic [1:0] pose,
  output logic       frame_tick
);

  localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [10:0] STEP_S   = 11'(WALK_STEP);
  localparam logic signed [5:0]  GRAV_S   = 6'(GRAVITY);

  logic tick;

  frame_tick_gen u_frame_tick_gen (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vs         (vs),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  state_t             state_reg, state_next;
  logic [9:0]         x_reg, x_next, y_reg, y_next;
  logic signed [5:0]  vy_reg, vy_next;
  logic signed [1:0]  air_dir_reg, air_dir_next;
  logic               facing_reg, facing_next;
  logic               armed_reg, armed_next;
  logic [2:0]         land_cnt_reg, land_cnt_next;
  logic signed [1:0]  dir, move_dir;
  logic signed [10:0] x_calc, y_calc;
  logic [9:0]         x_step;

  always_comb begin
    dir = 2'sd0;
    if (key_right && !key_left)      dir = 2'sd1;
    else if (key_left && !key_right) dir = -2'sd1;

    // Airborne motion follows the direction latched at takeoff, not the keys.
    move_dir = (state_reg == ST_AIR) ? air_dir_reg : dir;
    x_calc   = $signed({1'b0, x_reg});
    if (move_dir > 2'sd0)      x_calc = x_calc + STEP_S;
    else if (move_dir < 2'sd0) x_calc = x_calc - STEP_S;
    if (x_calc < X_MIN_S)      x_calc = X_MIN_S;
    else if (x_calc > X_MAX_S) x_calc = X_MAX_S;
    x_step = x_calc[9:0];

    y_calc = $signed({1'b0, y_reg}) - $signed({{5{vy_reg[5]}}, vy_reg});

    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    vy_next       = vy_reg;
    air_dir_next  = air_dir_reg;
    facing_next   = facing_reg;
    armed_next    = armed_reg;
    land_cnt_next = land_cnt_reg;

    case (state_reg)
      ST_STAND, ST_WALK: begin
        if (dir != 2'sd0) facing_next = dir[1];
        if (key_jump && armed_reg) begin
          state_next   = ST_AIR;
          vy_next      = 6'(JUMP_V0);
          air_dir_next = dir;
          armed_next   = 1'b0;
        end else if (dir != 2'sd0) begin
          state_next = ST_WALK;
          x_next     = x_step;
        end else begin
          state_next = ST_STAND;
        end
      end
      ST_AIR: begin
        x_next  = x_step;
        vy_next = vy_reg - GRAV_S;
        if (y_calc >= GROUND_S) begin
          y_next        = 10'(GROUND_Y);
          vy_next       = 6'sd0;
          land_cnt_next = 3'(LAND_FRAMES - 1);
          state_next    = ST_LAND;
        end else if (y_calc < 11'sd0) begin
          y_next  = 10'd0;
          vy_next = 6'sd0;
        end else begin
          y_next = y_calc[9:0];
        end
      end
      default: begin
        if (land_cnt_reg == 3'd0) state_next    = ST_STAND;
        else                      land_cnt_next = land_cnt_reg - 3'd1;
      end
    endcase

    if (!key_jump) armed_next = 1'b1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_STAND;
      x_reg        <= 10'(X_START);
      y_reg        <= 10'(GROUND_Y);
      vy_reg       <= 6'sd0;
      air_dir_reg  <= 2'sd0;
      facing_reg   <= 1'b0;
      armed_reg    <= 1'b1;
      land_cnt_reg <= 3'd0;
    end else if (tick) begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      vy_reg       <= vy_next;
      air_dir_reg  <= air_dir_next;
      facing_reg   <= facing_next;
      armed_reg    <= armed_next;
      land_cnt_reg <= land_cnt_next;
    end
  end

  assign AkumaX      = x_reg;
  assign AkumaY      = y_reg;
  assign facing_left = facing_reg;
  assign pose        = state_to_pose(state_reg);

endmodule

// File: doc/akuma_motion_controller.md
# akuma_motion_controller

Per-frame position and pose generator for the Akuma character. Takes player key levels and the VGA vertical sync, runs a walk/jump/land state machine once per frame, and drives the `AkumaX`/`AkumaY` top-left coordinates consumed by the Akuma sprite renderers. It also drives a pose select that picks which sprite renderer is enabled.

## Interface
- `X_START`, 100: reset X position.
- `X_MIN`, 0: leftmost legal X.
- `X_MAX`, 500: rightmost legal X (640 − 140 sprite width).
- `GROUND_Y`, 240: standing Y (480 − 240 sprite height).
- `WALK_STEP`, 3: pixels per frame while walking or airborne.
- `JUMP_V0`, 14: initial upward velocity, pixels per frame.
- `GRAVITY`, 1: velocity decrement per frame.
- `LAND_FRAMES`, 4: recovery frames after touchdown.

Ports:
- `vga_clk` in 1: the single clock. All logic runs on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vs` in 1: VGA vertical sync, active-low, synchronous to `vga_clk`.
- `key_left` in 1: level, left held.
- `key_right` in 1: level, right held.
- `key_jump` in 1: level, jump held.
- `AkumaX` out 10: sprite top-left X.
- `AkumaY` out 10: sprite top-left Y.
- `facing_left` out 1: horizontal mirror request.
- `pose` out 2: `pose_t`; STAND=0, WALK=1, JUMP=2, LAND=3.
- `frame_tick` out 1: one-cycle pulse marking the frame update.

## Operation
- **Frame tick**
  - `vs` is registered into `vs_q`, which resets to 1.
  - A falling edge (`vs_q`=1, `vs`=0) raises `frame_tick` for exactly one cycle on the next edge.
  - All state, velocity and position registers update only on cycles where the internal tick condition is true. They hold otherwise.
- **Direction**
  - `dir` = −1 for left only, +1 for right only, 0 for neither or both.
  - `facing_left` updates only when `dir` ≠ 0 and the state is STAND or WALK.
- **States** (`state_t`): ST_STAND, ST_WALK, ST_AIR, ST_LAND.
  - **ST_STAND / ST_WALK**
    - If `key_jump`=1 and `jump_armed`=1: go to ST_AIR, set `vy`=`JUMP_V0`, latch `air_dir`=`dir`, clear `jump_armed`.
    - Else if `dir`≠0: go to ST_WALK, X += `dir`·`WALK_STEP`.
    - Else: go to ST_STAND.
  - **ST_AIR**
    - Each frame: Y_next = Y − `vy` (11-bit signed), then `vy` −= `GRAVITY`. `vy` is a 6-bit signed register.
    - X += `air_dir`·`WALK_STEP`. Key changes are ignored while airborne.
    - If Y_next ≥ `GROUND_Y`: Y=`GROUND_Y`, `vy`=0, load land counter with `LAND_FRAMES`−1, go to ST_LAND.
    - If Y_next < 0: Y=0, `vy`=0 (ceiling).
  - **ST_LAND**
    - No motion.
    - The counter decrements each frame. At 0, go to ST_STAND.
- **Jump arming:** `jump_armed` sets on any tick with `key_jump`=0. Holding jump therefore produces exactly one jump.
- **X arithmetic:** computed 11-bit signed, then clamped to [`X_MIN`, `X_MAX`]. No wrap-around.
- **`pose`:** mirrors the state: STAND→STAND, WALK→WALK, AIR→JUMP, LAND→LAND.

## Timing
- **Reset values:**
  - `AkumaX`=`X_START`, `AkumaY`=`GROUND_Y`.
  - `facing_left`=0, `pose`=STAND, `frame_tick`=0.
  - State ST_STAND, `vy`=0, `jump_armed`=1, land counter 0.
- **Latency:** a `vs` falling edge sampled at edge N sets `frame_tick`=1 after edge N+1. `AkumaX`/`AkumaY`/`pose` change on that same edge N+1. Outputs are registered and stable for the entire frame.
- **Mid-operation reset:** reset asserted mid-jump or mid-land returns all outputs to their reset values immediately. Nothing is retained.
- **`vs` held low:** produces a single tick. No tick is generated while `vs` stays low.

## Structure
- **`akuma_pkg`:** `pose_t`, `state_t`, `SCREEN_W`=640, `SCREEN_H`=480, `SPRITE_W`=140, `SPRITE_H`=240.
- **Sub-module `frame_tick_gen`:** `vs` edge detector producing `frame_tick`.
- **Top level:** the remaining FSM and datapath in one `always_ff` plus an `always_comb` next-state block.

## Test plan
- **Walk right:** hold `key_right` for 10 ticks from reset → `AkumaX`=130, `pose`=WALK, `facing_left`=0. Release → `pose`=STAND after the next tick.
- **Right clamp:** X=497, hold right for 2 ticks → X=500, then stays 500.
- **Full jump:** pulse `key_jump` for 1 frame at X=100 with no direction.
  - `AkumaY` after 14 ticks = 135 (apex).
  - After 29 ticks `AkumaY`=240 and `pose`=LAND.
  - 4 ticks later `pose`=STAND.
- **Jump held:** `key_jump` held for 60 ticks → exactly one jump. After release plus one tick, a new press jumps again.
- **Both keys:** `key_left` and `key_right` both held → X unchanged, `pose`=STAND, `facing_left` unchanged.
- **Reset mid-jump:** assert `reset_n`=0 at tick 5 of a jump → X=100, Y=240, `pose`=STAND, `frame_tick`=0 with no clock edge required.
